sweep_ctrl: RTL
===============

SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 8: width of the phase-increment word driven to the sine generator.
REQ-002 Parameter DWELL_WIDTH, default 16: width of the per-tone dwell counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low (asserted when 0).
REQ-005 start  input  1  one-cycle request to begin a sweep; sampled only in IDLE.
REQ-006 abort  input  1  terminate the sweep in progress; no done pulse.
REQ-007 loop  input  1  sampled with start; 1 selects continuous repetition of the sweep.
REQ-008 f_start  input  ADDRESS_WIDTH  first increment of the sweep; sampled with start.
REQ-009 f_stop  input  ADDRESS_WIDTH  upper bound on the increment; sampled with start.
REQ-010 f_step  input  ADDRESS_WIDTH  increment added between tones; sampled with start.
REQ-011 dwell  input  DWELL_WIDTH  cycles each tone is held; sampled with start; 0 treated as 1.
REQ-012 en  output  1  enable to the sine generator's address counter.
REQ-013 incr  output  ADDRESS_WIDTH  current phase increment to the sine generator.
REQ-014 busy  output  1  high in RUN.
REQ-015 done  output  1  one-cycle pulse on normal completion.
REQ-016 wrap  output  1  one-cycle pulse when a looping sweep restarts at f_start.
REQ-017 err  output  1  sticky flag: last start request carried an illegal configuration.

Function
REQ-018 The FSM SHALL have the states IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-019 IDLE, start=1, with f_step!=0 and f_start<=f_stop: latch config, clear err, enter RUN next cycle with en=1, incr=f_start, dwell counter=0.
REQ-020 IDLE, start=1, with f_step==0 or f_start>f_stop: stay in IDLE, set err=1, hold en=0; no done pulse.
REQ-021 In RUN, en SHALL be 1 and incr SHALL equal the current tone; each tone SHALL be held for exactly max(dwell,1) cycles.
REQ-022 End of dwell: next = current + f_step, computed in ADDRESS_WIDTH+1 bits; next<=f_stop -> incr=next, counter cleared.
REQ-023 End of dwell, next>f_stop (incl. carry-out), loop=0 -> DONE next cycle: en=0, done=1, busy=0, incr holds last tone.
REQ-024 End of dwell, next>f_stop, loop=1 -> stay in RUN with incr=f_start and wrap=1 for one cycle; en stays 1 with no gap.
REQ-025 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-026 abort=1 in RUN SHALL force IDLE next cycle with en=0, busy=0, done=0, wrap=0; abort takes priority over every end-of-dwell transition.
REQ-027 abort in IDLE or DONE SHALL have no effect; start in RUN or DONE SHALL be ignored.
REQ-028 Config inputs SHALL be ignored after they are latched; changes during RUN SHALL have no effect until the next start.
REQ-029 f_start==f_stop SHALL yield a single tone of dwell cycles (loop=0) or that tone repeated with a wrap pulse every dwell cycles (loop=1).
REQ-030 done and wrap SHALL never be high in the same cycle.

Reset
REQ-031 rst=0 SHALL asynchronously force IDLE, en=0, incr=0, busy=0, done=0, wrap=0, err=0 and clear the dwell counter and latched config.
REQ-032 Reset asserted mid-sweep SHALL abandon the sweep with no done pulse; after release the block SHALL wait in IDLE for a new start.

Verification
REQ-033 f_start=4, f_stop=12, f_step=4, dwell=3, loop=0, start -> incr 4,4,4,8,8,8,12,12,12 with en=1, then done=1 for one cycle with en=0, incr=12.
REQ-034 Same config, loop=1 -> after 12x3, incr=4 with wrap=1 for one cycle and en held at 1; repeats until abort, then en=0 the next cycle and done never asserts.
REQ-035 f_start=250, f_stop=255, f_step=10, dwell=0 -> one cycle of incr=250, then done (no 8-bit wrap to 4).
REQ-036 f_step=0, or f_start=9 with f_stop=3 -> err=1, en stays 0, busy stays 0; a following legal start clears err.
REQ-037 Reset asserted mid-dwell on the second tone -> all outputs 0 immediately; start re-asserted after release -> sweep restarts at f_start.
REQ-038 start held high through RUN and DONE -> no restart until the first IDLE cycle; abort and end-of-dwell in the same cycle -> IDLE with done=0.

Source files
------------

// File: rtl/sweep_ctrl.sv
// Frequency sweep controller: steps a phase increment from f_start toward f_stop
// and holds each tone for a programmable dwell.
module sweep_ctrl #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DWELL_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     loop,
  input  logic [ADDRESS_WIDTH-1:0] f_start,
  input  logic [ADDRESS_WIDTH-1:0] f_stop,
  input  logic [ADDRESS_WIDTH-1:0] f_step,
  input  logic [DWELL_WIDTH-1:0]   dwell,
  output logic                     en,
  output logic [ADDRESS_WIDTH-1:0] incr,
  output logic                     busy,
  output logic                     done,
  output logic                     wrap,
  output logic                     err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = {{(DWELL_WIDTH-1){1'b0}}, 1'b1};

  state_t                   state_q, state_d;
  logic                     en_q, en_d;
  logic [ADDRESS_WIDTH-1:0] incr_q, incr_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     wrap_q, wrap_d;
  logic                     err_q, err_d;
  logic [DWELL_WIDTH-1:0]   cnt_q, cnt_d;
  logic                     loop_q, loop_d;
  logic [ADDRESS_WIDTH-1:0] start_q, start_d;
  logic [ADDRESS_WIDTH-1:0] stop_q, stop_d;
  logic [ADDRESS_WIDTH-1:0] step_q, step_d;
  logic [DWELL_WIDTH-1:0]   dwell_q, dwell_d;

  logic [ADDRESS_WIDTH:0]   next_tone;
  logic                     dwell_end;
  logic                     cfg_legal;

  // Extra bit keeps a carry-out from aliasing back below f_stop.
  assign next_tone = {1'b0, incr_q} + {1'b0, step_q};
  assign dwell_end = (cnt_q == dwell_q - DWELL_ONE);
  assign cfg_legal = (f_step != '0) && (f_start <= f_stop);

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    incr_d  = incr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    loop_d  = loop_q;
    start_d = start_q;
    stop_d  = stop_q;
    step_d  = step_q;
    dwell_d = dwell_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_legal) begin
            state_d = S_RUN;
            en_d    = 1'b1;
            busy_d  = 1'b1;
            incr_d  = f_start;
            cnt_d   = '0;
            err_d   = 1'b0;
            loop_d  = loop;
            start_d = f_start;
            stop_d  = f_stop;
            step_d  = f_step;
            dwell_d = (dwell == '0) ? DWELL_ONE : dwell;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (dwell_end) begin
          cnt_d = '0;
          if (next_tone <= {1'b0, stop_q}) begin
            incr_d = next_tone[ADDRESS_WIDTH-1:0];
          end else if (loop_q) begin
            incr_d = start_q;
            wrap_d = 1'b1;
          end else begin
            state_d = S_DONE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DWELL_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      incr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      loop_q  <= 1'b0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      incr_q  <= incr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      loop_q  <= loop_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
    end
  end

  assign en   = en_q;
  assign incr = incr_q;
  assign busy = busy_q;
  assign done = done_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule
